// File: rtl/gray_count_rx.sv
// Receive end of a Gray-coded counter link: synchronises the Gray word, decodes it to binary
// and flags legal single steps, wrap-around and skip/backward violations.
module gray_count_rx #(
  parameter int DATA_WIDTH    = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_WIDTH-1:0]    in_gray,
  output logic [DATA_WIDTH-1:0]    out_bin,
  output logic                     locked,
  output logic                     step,
  output logic                     wrap,
  output logic                     err,
  output logic [ERR_CNT_WIDTH-1:0] err_count
);

  localparam int FILL_W = 3;
  localparam logic [DATA_WIDTH-1:0] ONE      = DATA_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0] ZERO     = '0;
  localparam logic [DATA_WIDTH-1:0] ALL_ONES = '1;
  localparam logic [ERR_CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [ERR_CNT_WIDTH-1:0] CNT_ONE = ERR_CNT_WIDTH'(1);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(SYNC_STAGES);

  typedef enum logic {FILL = 1'b0, TRACK = 1'b1} state_t;

  function automatic logic [DATA_WIDTH-1:0] gray_to_bin(input logic [DATA_WIDTH-1:0] g);
    logic [DATA_WIDTH-1:0] b;
    b[DATA_WIDTH-1] = g[DATA_WIDTH-1];
    for (int i = DATA_WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [DATA_WIDTH-1:0] s;
  logic [DATA_WIDTH-1:0] bin;
  logic [DATA_WIDTH-1:0] delta;
  state_t                state;
  logic [FILL_W-1:0]     fill_cnt;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign s = in_gray;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0][DATA_WIDTH-1:0] chain;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          chain <= '0;
        end else begin
          chain[0] <= in_gray;
          for (int i = 1; i < SYNC_STAGES; i++) begin
            chain[i] <= chain[i-1];
          end
        end
      end

      assign s = chain[SYNC_STAGES-1];
    end
  endgenerate

  assign bin   = gray_to_bin(s);
  assign delta = bin - out_bin;

  // FILL waits out the reset zeros still travelling through the sync chain before locking
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= FILL;
      fill_cnt  <= '0;
      out_bin   <= '0;
      locked    <= 1'b0;
      step      <= 1'b0;
      wrap      <= 1'b0;
      err       <= 1'b0;
      err_count <= '0;
    end else begin
      step <= 1'b0;
      wrap <= 1'b0;
      err  <= 1'b0;
      case (state)
        FILL: begin
          if (fill_cnt == FILL_LAST) begin
            state   <= TRACK;
            out_bin <= bin;
            locked  <= 1'b1;
          end else begin
            fill_cnt <= fill_cnt + FILL_W'(1);
          end
        end
        TRACK: begin
          if (delta == ONE) begin
            out_bin <= bin;
            step    <= 1'b1;
            wrap    <= (out_bin == ALL_ONES);
          end else if (delta != ZERO) begin
            out_bin <= bin;
            err     <= 1'b1;
            if (err_count != CNT_MAX) begin
              err_count <= err_count + CNT_ONE;
            end else begin
              err_count <= err_count;
            end
          end else begin
            out_bin <= out_bin;
          end
        end
        default: begin
          state <= FILL;
        end
      endcase
    end
  end

endmodule
